arb_burst_sched: RTL

ARB_BURST_SCHED -- requirements
Module: arb_burst_sched

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_prio_pick.sv | 37 +++
 rtl/arb_burst_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state type and default sizes for arb_burst_sched
//
// Purpose : FSM state enum plus default requester count and burst length.
// Ports   : none (package).
package arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 8;
  localparam int BEAT_W        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_prio_pick.sv
// rtl/rr_prio_pick.sv - combinational rotating-priority winner search
//
// Purpose : picks the first requester at or after last_owner+1 (mod NUM_REQ).
// Ports   : req        - request vector
//           last_owner - index of the previous owner (lowest priority)
//           winner     - one-hot winner, zero when no request
//           valid      - high when any request is present
module rr_prio_pick
  import arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_owner,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [IDW-1:0] idx;

  // Walk NUM_REQ positions starting just after last_owner; the previous
  // owner itself is visited last, so it only wins when nobody else asks.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((int'(last_owner) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_burst_sched.sv
// rtl/arb_burst_sched.sv - round-robin arbiter with optional burst limit
//
// Purpose : grants one requester at a time, holds the grant until done,
//           request drop or (with ARB_BURST_LIMIT_EN defined) MAX_BURST
//           grant cycles, then inserts a one-cycle gap before rearbitrating.
// Ports   : clk             - clock, rising edge
//           rst             - asynchronous active-low reset
//           req             - level requests, one per requester
//           done            - transfer complete, only the owner's bit matters
//           gnt             - registered one-hot grant
//           gnt_id          - registered owner index, 0 with no owner
//           busy            - high while gnt is non-zero
//           burst_limit_hit - one-cycle pulse in the gap after a limit revoke
// Config  : ARB_BURST_LIMIT_EN enables the beat counter and burst limit.
module arb_burst_sched
  import arb_pkg::*;
#(
  parameter  int NUM_REQ   = NUM_REQ_DEF,
  parameter  int MAX_BURST = MAX_BURST_DEF,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               busy,
  output logic               burst_limit_hit
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_cfg_check
    $error("arb_burst_sched: NUM_REQ or MAX_BURST out of range");
  end

  arb_state_e         state;
  logic [IDW-1:0]     last_owner;
  logic [NUM_REQ-1:0] pick_winner;
  logic               pick_valid;
  logic [IDW-1:0]     pick_idx;
  logic               owner_req;
  logic               owner_done;
  logic               limit_hit;
  logic               release_now;

  rr_prio_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_winner[i]) pick_idx = IDW'(i);
    end
  end

  assign owner_req  = req[gnt_id];
  assign owner_done = done[gnt_id];

`ifdef ARB_BURST_LIMIT_EN
  logic [BEAT_W-1:0] beat_cnt;
  // beat_cnt is 0 in the first grant cycle, so MAX_BURST-1 marks the last one.
  assign limit_hit = (beat_cnt == BEAT_W'(MAX_BURST - 1));
`else
  assign limit_hit       = 1'b0;
  assign burst_limit_hit = 1'b0;
`endif

  assign release_now = owner_done || !owner_req || limit_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_id     <= '0;
      busy       <= 1'b0;
      last_owner <= IDW'(NUM_REQ - 1);
`ifdef ARB_BURST_LIMIT_EN
      beat_cnt        <= '0;
      burst_limit_hit <= 1'b0;
`endif
    end else begin
`ifdef ARB_BURST_LIMIT_EN
      burst_limit_hit <= 1'b0;
`endif
      case (state)
        IDLE, GAP: begin
          if (pick_valid) begin
            state  <= GRANT;
            gnt    <= pick_winner;
            gnt_id <= pick_idx;
            busy   <= 1'b1;
`ifdef ARB_BURST_LIMIT_EN
            beat_cnt <= '0;
`endif
          end else begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
          end
        end
        GRANT: begin
`ifdef ARB_BURST_LIMIT_EN
          beat_cnt <= beat_cnt + 1'b1;
`endif
          if (release_now) begin
            state      <= GAP;
            gnt        <= '0;
            gnt_id     <= '0;
            busy       <= 1'b0;
            last_owner <= gnt_id;
`ifdef ARB_BURST_LIMIT_EN
            // Only a pure limit revoke is flagged; a coincident done or
            // request drop counts as a normal release.
            burst_limit_hit <= limit_hit && !owner_done && owner_req;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          gnt    <= '0;
          gnt_id <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
